// File: rtl/video_source_mux.sv
// N-channel RGB source selector for the VGA driver. Source swaps happen only on
// frame boundaries, with an optional multi-frame fade-to-black between sources.
module video_source_mux #(
  parameter int unsigned N_SRC       = 4,
  parameter int unsigned COLOR_W     = 8,
  parameter int unsigned FADE_EN     = 1,
  parameter int unsigned FADE_LOG2   = 3,
  parameter int unsigned DEFAULT_SEL = 0,
  localparam int unsigned SEL_W      = $clog2(N_SRC)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic                       sel_valid,
  input  logic [SEL_W-1:0]           sel,
  input  logic [N_SRC*COLOR_W-1:0]   r_in,
  input  logic [N_SRC*COLOR_W-1:0]   g_in,
  input  logic [N_SRC*COLOR_W-1:0]   b_in,
  output logic [COLOR_W-1:0]         r,
  output logic [COLOR_W-1:0]         g,
  output logic [COLOR_W-1:0]         b,
  output logic [SEL_W-1:0]           active_sel,
  output logic                       busy
);

  localparam int unsigned LVL_W  = FADE_LOG2 + 1;
  localparam int unsigned PROD_W = COLOR_W + FADE_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(2 ** FADE_LOG2);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FADE_OUT,
    ST_BLACK,
    ST_FADE_IN,
    ST_CUT_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] pend, pend_nxt;
  logic [SEL_W-1:0] active_nxt;
  logic [LVL_W-1:0] level, level_nxt;
  logic             req_ok;
  logic             fs_eff;

  logic [COLOR_W-1:0] r_arr [N_SRC];
  logic [COLOR_W-1:0] g_arr [N_SRC];
  logic [COLOR_W-1:0] b_arr [N_SRC];
  logic [PROD_W-1:0]  prod_r, prod_g, prod_b;

  // Unpack the flat per-source colour buses
  for (genvar i = 0; i < int'(N_SRC); i++) begin : g_unpack
    assign r_arr[i] = r_in[i*COLOR_W +: COLOR_W];
    assign g_arr[i] = g_in[i*COLOR_W +: COLOR_W];
    assign b_arr[i] = b_in[i*COLOR_W +: COLOR_W];
  end

  // Out-of-range requests are dropped; an accepted request consumes a coincident frame_start
  assign req_ok = sel_valid && (32'(sel) < N_SRC);
  assign fs_eff = frame_start && !req_ok;

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    level_nxt  = level;
    active_nxt = active_sel;
    if (FADE_EN != 0) begin
      case (state)
        ST_IDLE: begin
          if (req_ok && (sel != active_sel)) begin
            pend_nxt  = sel;
            state_nxt = ST_FADE_OUT;
          end
        end
        ST_FADE_OUT: begin
          if (req_ok) begin
            pend_nxt = sel;
            // Reversing before any dimming step lands straight back in IDLE
            if (sel == active_sel) begin
              state_nxt = (level == LVL_MAX) ? ST_IDLE : ST_FADE_IN;
            end
          end else if (fs_eff) begin
            level_nxt = level - LVL_ONE;
            if (level == LVL_ONE) begin
              state_nxt = ST_BLACK;
            end
          end
        end
        ST_BLACK: begin
          if (req_ok) begin
            pend_nxt = sel;
          end else if (fs_eff) begin
            active_nxt = pend;
            level_nxt  = LVL_ONE;
            state_nxt  = ST_FADE_IN;
          end
        end
        ST_FADE_IN: begin
          if (req_ok) begin
            if (sel != active_sel) begin
              pend_nxt  = sel;
              state_nxt = ST_FADE_OUT;
            end
          end else if (fs_eff) begin
            level_nxt = level + LVL_ONE;
            if (level == (LVL_MAX - LVL_ONE)) begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_ok && (sel != active_sel)) begin
            pend_nxt  = sel;
            state_nxt = ST_CUT_WAIT;
          end
        end
        ST_CUT_WAIT: begin
          if (req_ok) begin
            pend_nxt = sel;
          end else if (fs_eff) begin
            active_nxt = pend;
            state_nxt  = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      pend       <= SEL_W'(DEFAULT_SEL);
      active_sel <= SEL_W'(DEFAULT_SEL);
      level      <= LVL_MAX;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend       <= pend_nxt;
      active_sel <= active_nxt;
      level      <= level_nxt;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  // Dimming multiply; level = LVL_MAX is an exact pass-through
  always_comb begin
    prod_r = PROD_W'(r_arr[active_sel]) * PROD_W'(level);
    prod_g = PROD_W'(g_arr[active_sel]) * PROD_W'(level);
    prod_b = PROD_W'(b_arr[active_sel]) * PROD_W'(level);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      r <= COLOR_W'(prod_r >> FADE_LOG2);
      g <= COLOR_W'(prod_g >> FADE_LOG2);
      b <= COLOR_W'(prod_b >> FADE_LOG2);
    end
  end

endmodule
